vector_register_file: RTL and testbench
=======================================

Name: vector_register_file

Overview:
- Parametrised multi-entry, multi-lane vector register file for the vectorial ASIP datapath.
- Generalises the single N-bit pipeline register into:
  - DEPTH entries of LANES x LANE_W bits.
  - Per-lane write masking.
  - Two combinational read ports with optional same-cycle write bypass.
  - Optional hard-wired zero entry.
- Sits between decode (operand fetch) and writeback of the vector pipeline.

Parameters:
- LANES, 4, number of vector lanes per entry (>=1).
- LANE_W, 16, bits per lane (>=1).
- DEPTH, 8, number of vector registers (>=2).
- BYPASS, 1, 1 = a read of the address being written this cycle returns the new merged data; 0 = it returns the stored (old) data.
- ZERO_REG, 1, 1 = entry 0 always reads as zero and ignores writes.
- Derived, not overridable: ADDR_W = max(1, clog2(DEPTH)); VEC_W = LANES*LANE_W.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- we, input, 1, write enable.
- waddr, input, ADDR_W, write address.
- wdata, input, VEC_W, write data; lane i occupies bits [i*LANE_W +: LANE_W].
- wmask, input, LANES, per-lane write enable; bit i gates lane i.
- raddr_a, input, ADDR_W, read address, port A.
- raddr_b, input, ADDR_W, read address, port B.
- rdata_a, output, VEC_W, read data, port A.
- rdata_b, output, VEC_W, read data, port B.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high, sampled only on the rising edge of clk.
- Reset:
  - When reset=1 at a rising edge, all DEPTH entries clear to 0.
  - A write presented in the same cycle is discarded; reset has priority.
  - During the reset cycle, reads still follow the combinational rules below.
  - After the reset edge, rdata_a and rdata_b read 0 for every address.
- Write, at a rising edge with reset=0 and we=1:
  - For each lane i with wmask[i]=1, entry[waddr] lane i <= wdata lane i.
  - Lanes with wmask[i]=0 keep their value.
  - we=1 with wmask=0 is a legal no-op.
- Write latency: one cycle. Data is stored at the edge and visible in stored state from the next cycle.
- Read: combinational from raddr_x to rdata_x, zero cycles. No read enable. Ports A and B are fully independent; they may use the same address.
- Bypass, when BYPASS=1, we=1, reset=0 and raddr_x==waddr:
  - rdata_x = per-lane mux of wdata (masked lanes) and the stored lanes (unmasked lanes).
- Bypass, when BYPASS=0: rdata_x = stored value until the edge.
- ZERO_REG=1:
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0 on both ports.
  - No bypass is applied for address 0.
- Out-of-range addresses (DEPTH not a power of 2, address >= DEPTH):
  - Writes are ignored.
  - Reads return 0.
  - Bypass never applies.
- Reset mid-operation: any write in flight is lost; there are no pending states.
- No X propagation from unwritten entries; all entries are reset-defined.

Decomposition:
- Shared package vrf_pkg:
  - Default LANES, LANE_W, DEPTH constants.
  - Derived VEC_W and ADDR_W functions.
  - Typedefs lane_t (LANE_W bits), vec_t (LANES x lane_t), vaddr_t.
  - These are reused by decode, ALU lanes and writeback.
- One natural sub-module: vrf_read_port.
  - Address decode, range/zero check, bypass merge.
  - Instantiated twice, for ports A and B.
- Storage and write logic stay in the top module.

Test Plan:
- Reset clear: write 0xAAAA to all lanes of entries 1..7; assert reset for one cycle → every address reads 0x0000_0000_0000_0000 on both ports.
- Masked write: write entry 3 = 0x4444_3333_2222_1111 with wmask=4'b1111, then wdata=0xFFFF_FFFF_FFFF_FFFF with wmask=4'b0101 → entry 3 reads 0x4444_FFFF_2222_FFFF.
- Bypass: BYPASS=1, entry 5 = 0x0; same cycle we=1, waddr=5, wmask=4'b0011, wdata=0x1234_5678_9ABC_DEF0, raddr_a=5 → rdata_a=0x0000_0000_9ABC_DEF0 combinationally. Repeat with BYPASS=0 → rdata_a=0x0 until the edge, 0x0000_0000_9ABC_DEF0 after.
- Zero register: ZERO_REG=1; write 0xDEAD to all lanes of address 0 → rdata_a and rdata_b at address 0 read 0. With ZERO_REG=0 → reads 0xDEAD_DEAD_DEAD_DEAD.
- Reset priority: same edge reset=1, we=1, waddr=2, wdata all-ones → entry 2 reads 0 afterwards.
- Non-power-of-2: DEPTH=6; write to address 7 → ignored, and a read of address 7 returns 0. Dual-port read of entries 1 and 4 in the same cycle returns each entry's independent value.

Source files
------------

// File: rtl/vrf_pkg.sv
// Shared vector register file types and sizing helpers, reused by decode,
// ALU lanes and writeback.
package vrf_pkg;

   localparam int DEF_LANES  = 4;
   localparam int DEF_LANE_W = 16;
   localparam int DEF_DEPTH  = 8;

   function automatic int vrf_addr_w(input int depth);
      return ($clog2(depth) > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int vrf_vec_w(input int lanes, input int lane_w);
      return lanes * lane_w;
   endfunction

   typedef logic [DEF_LANE_W-1:0]            lane_t;
   typedef lane_t [DEF_LANES-1:0]            vec_t;
   typedef logic [vrf_addr_w(DEF_DEPTH)-1:0] vaddr_t;

endpackage

// File: rtl/vrf_read_port.sv
// One combinational read port: address decode, range and zero-entry check,
// and per-lane merge of the in-flight write when bypass is enabled.
module vrf_read_port
   import vrf_pkg::*;
#(
   parameter int  LANES    = DEF_LANES,
   parameter int  LANE_W   = DEF_LANE_W,
   parameter int  DEPTH    = DEF_DEPTH,
   parameter int  BYPASS   = 1,
   parameter int  ZERO_REG = 1,
   localparam int ADDR_W   = vrf_addr_w(DEPTH),
   localparam int VEC_W    = vrf_vec_w(LANES, LANE_W)
) (
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [VEC_W-1:0]  wdata,
   input  logic [LANES-1:0]  wmask,
   input  logic [VEC_W-1:0]  mem [DEPTH],
   input  logic [ADDR_W-1:0] raddr,
   output logic [VEC_W-1:0]  rdata
);

   logic [VEC_W-1:0] stored;
   logic [VEC_W-1:0] merged;
   logic             in_range;
   logic             is_zero;
   logic             bypass_hit;

   // Only valid entries are decoded, so an out-of-range address reads 0.
   always_comb begin
      stored = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (raddr == ADDR_W'(i)) begin
            stored = mem[i];
         end
      end
   end

   assign in_range   = ({1'b0, raddr} < (ADDR_W+1)'(DEPTH));
   assign is_zero    = (ZERO_REG != 0) && (raddr == '0);
   assign bypass_hit = (BYPASS != 0) && we && !reset && (raddr == waddr)
                       && in_range && !is_zero;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign merged[gi*LANE_W +: LANE_W] = (bypass_hit && wmask[gi])
                                            ? wdata[gi*LANE_W +: LANE_W]
                                            : stored[gi*LANE_W +: LANE_W];
      end
   endgenerate

   assign rdata = is_zero ? '0 : merged;

endmodule

// File: rtl/vector_register_file.sv
// Multi-entry, multi-lane vector register file: lane-masked synchronous
// write, two independent combinational read ports with optional bypass.
module vector_register_file
   import vrf_pkg::*;
#(
   parameter int  LANES    = DEF_LANES,
   parameter int  LANE_W   = DEF_LANE_W,
   parameter int  DEPTH    = DEF_DEPTH,
   parameter int  BYPASS   = 1,
   parameter int  ZERO_REG = 1,
   localparam int ADDR_W   = vrf_addr_w(DEPTH),
   localparam int VEC_W    = vrf_vec_w(LANES, LANE_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [VEC_W-1:0]  wdata,
   input  logic [LANES-1:0]  wmask,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [VEC_W-1:0]  rdata_a,
   output logic [VEC_W-1:0]  rdata_b
);

   logic [VEC_W-1:0] mem_q [DEPTH];
   logic [VEC_W-1:0] mem_d [DEPTH];
   logic             wr_ok;

   // Entry 0 stays zero under ZERO_REG because it is never written.
   assign wr_ok = we && ({1'b0, waddr} < (ADDR_W+1)'(DEPTH))
                  && !((ZERO_REG != 0) && (waddr == '0));

   always_comb begin
      for (int e = 0; e < DEPTH; e++) begin
         mem_d[e] = mem_q[e];
         if (wr_ok && (waddr == ADDR_W'(e))) begin
            for (int l = 0; l < LANES; l++) begin
               if (wmask[l]) begin
                  mem_d[e][l*LANE_W +: LANE_W] = wdata[l*LANE_W +: LANE_W];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int e = 0; e < DEPTH; e++) begin
            mem_q[e] <= '0;
         end
      end else begin
         for (int e = 0; e < DEPTH; e++) begin
            mem_q[e] <= mem_d[e];
         end
      end
   end

   vrf_read_port #(
      .LANES    (LANES),
      .LANE_W   (LANE_W),
      .DEPTH    (DEPTH),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
   ) u_read_a (
      .reset (reset),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .wmask (wmask),
      .mem   (mem_q),
      .raddr (raddr_a),
      .rdata (rdata_a)
   );

   vrf_read_port #(
      .LANES    (LANES),
      .LANE_W   (LANE_W),
      .DEPTH    (DEPTH),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
   ) u_read_b (
      .reset (reset),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .wmask (wmask),
      .mem   (mem_q),
      .raddr (raddr_b),
      .rdata (rdata_b)
   );

endmodule

// File: tb/tb_vector_register_file.sv
// Directed bench: three configurations (default, no-bypass/no-zero-reg,
// DEPTH=6) share one stimulus stream and are checked against fixed values.
module tb_vector_register_file;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        we = 1'b0;
   logic [2:0]  waddr = '0;
   logic [63:0] wdata = '0;
   logic [3:0]  wmask = '0;
   logic [2:0]  raddr_a = '0;
   logic [2:0]  raddr_b = '0;
   logic [63:0] a_rd_a, a_rd_b, b_rd_a, b_rd_b, c_rd_a, c_rd_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vector_register_file dut_a (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .wmask(wmask), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(a_rd_a), .rdata_b(a_rd_b)
   );

   vector_register_file #(.BYPASS(0), .ZERO_REG(0)) dut_b (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .wmask(wmask), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(b_rd_a), .rdata_b(b_rd_b)
   );

   vector_register_file #(.DEPTH(6)) dut_c (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .wmask(wmask), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(c_rd_a), .rdata_b(c_rd_b)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_write(input logic [2:0] a, input logic [63:0] d, input logic [3:0] m);
      we    = 1'b1;
      waddr = a;
      wdata = d;
      wmask = m;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int a = 0; a < 8; a++) begin
         @(negedge clk);
         raddr_a = 3'(a);
         raddr_b = 3'(7 - a);
         #1;
         checks++;
         if (a_rd_a !== 64'h0 || a_rd_b !== 64'h0) begin
            errors++;
            $display("FAIL reset_init addr=%0d got a=%h b=%h exp 0", a, a_rd_a, a_rd_b);
         end
      end
      for (int a = 1; a < 8; a++) begin
         set_write(3'(a), 64'hAAAA_AAAA_AAAA_AAAA, 4'b1111);
         tick();
      end
      we = 1'b0;
      raddr_a = 3'd1;
      raddr_b = 3'd7;
      #1;
      checks++;
      if (a_rd_a !== 64'hAAAA_AAAA_AAAA_AAAA || b_rd_b !== 64'hAAAA_AAAA_AAAA_AAAA) begin
         errors++;
         $display("FAIL fill got a=%h b=%h exp AAAAAAAAAAAAAAAA", a_rd_a, b_rd_b);
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int a = 0; a < 8; a++) begin
         @(negedge clk);
         raddr_a = 3'(a);
         raddr_b = 3'(a);
         #1;
         checks++;
         if (a_rd_a !== 64'h0 || a_rd_b !== 64'h0 || b_rd_a !== 64'h0 || b_rd_b !== 64'h0) begin
            errors++;
            $display("FAIL reset_clear addr=%0d got %h %h %h %h exp 0", a, a_rd_a, a_rd_b, b_rd_a, b_rd_b);
         end
      end
   endtask

   task automatic test_masked_write();
      @(negedge clk);
      set_write(3'd3, 64'h4444_3333_2222_1111, 4'b1111);
      tick();
      set_write(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0101);
      tick();
      we = 1'b0;
      raddr_a = 3'd3;
      raddr_b = 3'd3;
      #1;
      checks++;
      if (a_rd_a !== 64'h4444_FFFF_2222_FFFF) begin
         errors++;
         $display("FAIL masked_write_a got=%h exp=4444ffff2222ffff", a_rd_a);
      end
      checks++;
      if (b_rd_b !== 64'h4444_FFFF_2222_FFFF) begin
         errors++;
         $display("FAIL masked_write_b got=%h exp=4444ffff2222ffff", b_rd_b);
      end
   endtask

   task automatic test_bypass();
      @(negedge clk);
      set_write(3'd5, 64'h1234_5678_9ABC_DEF0, 4'b0011);
      raddr_a = 3'd5;
      raddr_b = 3'd4;
      #1;
      checks++;
      if (a_rd_a !== 64'h0000_0000_9ABC_DEF0) begin
         errors++;
         $display("FAIL bypass_on got=%h exp=000000009abcdef0", a_rd_a);
      end
      checks++;
      if (b_rd_a !== 64'h0) begin
         errors++;
         $display("FAIL bypass_off_before got=%h exp=0", b_rd_a);
      end
      checks++;
      if (a_rd_b !== 64'h0) begin
         errors++;
         $display("FAIL bypass_other_addr got=%h exp=0", a_rd_b);
      end
      tick();
      we = 1'b0;
      #1;
      checks++;
      if (b_rd_a !== 64'h0000_0000_9ABC_DEF0 || a_rd_a !== 64'h0000_0000_9ABC_DEF0) begin
         errors++;
         $display("FAIL bypass_after_edge got nb=%h b=%h exp=000000009abcdef0", b_rd_a, a_rd_a);
      end
   endtask

   task automatic test_zero_reg();
      @(negedge clk);
      set_write(3'd0, 64'hDEAD_DEAD_DEAD_DEAD, 4'b1111);
      raddr_a = 3'd0;
      raddr_b = 3'd0;
      #1;
      checks++;
      if (a_rd_a !== 64'h0) begin
         errors++;
         $display("FAIL zero_reg_no_bypass got=%h exp=0", a_rd_a);
      end
      tick();
      we = 1'b0;
      #1;
      checks++;
      if (a_rd_a !== 64'h0 || a_rd_b !== 64'h0) begin
         errors++;
         $display("FAIL zero_reg_read got a=%h b=%h exp 0", a_rd_a, a_rd_b);
      end
      checks++;
      if (b_rd_a !== 64'hDEAD_DEAD_DEAD_DEAD || b_rd_b !== 64'hDEAD_DEAD_DEAD_DEAD) begin
         errors++;
         $display("FAIL no_zero_reg_read got a=%h b=%h exp deaddeaddeaddead", b_rd_a, b_rd_b);
      end
   endtask

   task automatic test_reset_priority();
      @(negedge clk);
      set_write(3'd2, 64'h5555_5555_5555_5555, 4'b1111);
      tick();
      reset = 1'b1;
      set_write(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1111);
      raddr_a = 3'd2;
      #1;
      checks++;
      if (a_rd_a !== 64'h5555_5555_5555_5555) begin
         errors++;
         $display("FAIL reset_cycle_read got=%h exp=5555555555555555", a_rd_a);
      end
      tick();
      reset = 1'b0;
      we = 1'b0;
      #1;
      checks++;
      if (a_rd_a !== 64'h0 || b_rd_a !== 64'h0 || c_rd_a !== 64'h0) begin
         errors++;
         $display("FAIL reset_priority got %h %h %h exp 0", a_rd_a, b_rd_a, c_rd_a);
      end
   endtask

   task automatic test_non_pow2();
      @(negedge clk);
      set_write(3'd7, 64'h7777_7777_7777_7777, 4'b1111);
      raddr_a = 3'd7;
      raddr_b = 3'd7;
      #1;
      checks++;
      if (c_rd_a !== 64'h0 || a_rd_a !== 64'h7777_7777_7777_7777) begin
         errors++;
         $display("FAIL oor_bypass got d6=%h d8=%h exp 0 / 7777777777777777", c_rd_a, a_rd_a);
      end
      tick();
      we = 1'b0;
      #1;
      checks++;
      if (c_rd_a !== 64'h0 || c_rd_b !== 64'h0) begin
         errors++;
         $display("FAIL oor_write got a=%h b=%h exp 0", c_rd_a, c_rd_b);
      end
      set_write(3'd1, 64'h1111_0001_1111_0001, 4'b1111);
      tick();
      set_write(3'd4, 64'h4444_0004_4444_0004, 4'b1111);
      tick();
      set_write(3'd5, 64'h5A5A_5A5A_5A5A_5A5A, 4'b1111);
      tick();
      we = 1'b0;
      raddr_a = 3'd1;
      raddr_b = 3'd4;
      #1;
      checks++;
      if (c_rd_a !== 64'h1111_0001_1111_0001 || c_rd_b !== 64'h4444_0004_4444_0004) begin
         errors++;
         $display("FAIL dual_read got a=%h b=%h exp 1111000111110001 / 4444000444440004", c_rd_a, c_rd_b);
      end
      raddr_a = 3'd5;
      raddr_b = 3'd6;
      #1;
      checks++;
      if (c_rd_a !== 64'h5A5A_5A5A_5A5A_5A5A || c_rd_b !== 64'h0) begin
         errors++;
         $display("FAIL last_entry got a=%h b=%h exp 5a5a5a5a5a5a5a5a / 0", c_rd_a, c_rd_b);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      set_write(3'd6, 64'hAAAA_BBBB_CCCC_0001, 4'b0001);
      tick();
      set_write(3'd6, 64'h0004_BBBB_CCCC_DDDD, 4'b1000);
      raddr_a = 3'd6;
      raddr_b = 3'd6;
      #1;
      checks++;
      if (a_rd_a !== 64'h0004_0000_0000_0001) begin
         errors++;
         $display("FAIL b2b_bypass got=%h exp=0004000000000001", a_rd_a);
      end
      checks++;
      if (b_rd_b !== 64'h0000_0000_0000_0001) begin
         errors++;
         $display("FAIL b2b_nobypass got=%h exp=0000000000000001", b_rd_b);
      end
      tick();
      we = 1'b0;
      #1;
      checks++;
      if (a_rd_b !== 64'h0004_0000_0000_0001 || b_rd_a !== 64'h0004_0000_0000_0001) begin
         errors++;
         $display("FAIL b2b_stored got a=%h b=%h exp 0004000000000001", a_rd_b, b_rd_a);
      end
   endtask

   initial begin
      test_reset();
      test_masked_write();
      test_bypass();
      test_zero_reg();
      test_reset_priority();
      test_non_pow2();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
